// File: rtl/adder_result_checker.sv
// Response checker for the adder test environment: captures each applied vector with the
// adder's result, recomputes the golden sum one stage later, and tracks counts and the first failure.
module adder_result_checker #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             halt_on_err,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             halted,
  output logic             error_flag,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t state, state_nxt;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1, b_p1, sum_p1;
  logic             cin_p1, cout_p1;
  logic [WIDTH:0]   golden_p1;
  logic             mism_p1;
  logic             halt_now;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A failing compare that halts also drops the vector presented on that same edge.
  assign golden_p1 = {1'b0, a_p1} + {1'b0, b_p1} + {{WIDTH{1'b0}}, cin_p1};
  assign mism_p1   = vld_p1 && ({cout_p1, sum_p1} != golden_p1);
  assign halt_now  = mism_p1 && halt_on_err && (state == RUN);
  assign accept    = (state == RUN) && enable && in_valid && !halt_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (halt_now) state_nxt = HALT;
               else if (!enable) state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_comb begin
    busy   = (state == RUN);
    halted = (state == HALT);
  end

  // Stage 1: capture vector and reported result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept && !clear;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1    <= a;
      b_p1    <= b;
      cin_p1  <= c_in;
      sum_p1  <= dut_sum;
      cout_p1 <= dut_cout;
    end
  end

  // Stage 2: compare against golden, update counters and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count  <= '0;
      err_count  <= '0;
      error_flag <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_sum   <= '0;
      fail_cout  <= 1'b0;
    end else if (clear) begin
      vec_count  <= '0;
      err_count  <= '0;
      error_flag <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_sum   <= '0;
      fail_cout  <= 1'b0;
    end else begin
      if (vld_p1) vec_count <= sat_inc(vec_count);
      if (mism_p1) begin
        err_count  <= sat_inc(err_count);
        error_flag <= 1'b1;
        if (!error_flag) begin
          fail_a    <= a_p1;
          fail_b    <= b_p1;
          fail_cin  <= cin_p1;
          fail_sum  <= sum_p1;
          fail_cout <= cout_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed and randomized bench for adder_result_checker, checked against a transaction-level
// model of the checker's observable behaviour.
module tb_adder_result_checker;
  localparam int WIDTH = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, enable, clear, halt_on_err, in_valid, c_in, dut_cout;
  logic [WIDTH-1:0] a, b, dut_sum;
  logic             busy, halted, error_flag, fail_cin, fail_cout;
  logic [CNT_W-1:0] vec_count, err_count;
  logic [WIDTH-1:0] fail_a, fail_b, fail_sum;

  adder_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .halt_on_err(halt_on_err),
    .in_valid(in_valid), .a(a), .b(b), .c_in(c_in), .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .halted(halted), .error_flag(error_flag), .vec_count(vec_count),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
    .fail_sum(fail_sum), .fail_cout(fail_cout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] a, b, s;
    logic        ci, co;
  } vec_t;

  vec_t        pend[$];
  bit          m_busy, m_halted, m_flag;
  int          m_vec, m_err;
  logic [63:0] m_fa, m_fb, m_fs;
  logic        m_fci, m_fco;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_halted = 0; m_flag = 0; m_vec = 0; m_err = 0;
    m_fa = '0; m_fb = '0; m_fs = '0; m_fci = 0; m_fco = 0;
    pend.delete();
  endtask

  // Applied at each rising edge with the inputs that were present at that edge.
  task automatic model_edge();
    vec_t        v;
    logic [64:0] g;
    bit          bad;
    bit          halting;
    halting = 0;
    if (clear) begin
      model_reset();
      return;
    end
    if (pend.size() > 0) begin
      v   = pend.pop_front();
      g   = 65'(v.a) + 65'(v.b) + 65'(v.ci);
      bad = (v.s !== g[63:0]) || (v.co !== g[64]);
      m_vec = (m_vec < CMAX) ? m_vec + 1 : CMAX;
      if (bad) begin
        m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
        if (!m_flag) begin
          m_fa = v.a; m_fb = v.b; m_fci = v.ci; m_fs = v.s; m_fco = v.co;
        end
        m_flag  = 1;
        halting = halt_on_err && m_busy;
      end
    end
    if (m_busy && enable && in_valid && !halting) begin
      v.a = a; v.b = b; v.ci = c_in; v.s = dut_sum; v.co = dut_cout;
      pend.push_back(v);
    end
    if (!m_halted) begin
      if (m_busy) begin
        if (halting) begin
          m_busy = 0; m_halted = 1;
        end else if (!enable) begin
          m_busy = 0;
        end
      end else if (enable) begin
        m_busy = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},       busy,       64'(m_busy));
    chk({tag, ".halted"},     halted,     64'(m_halted));
    chk({tag, ".error_flag"}, error_flag, 64'(m_flag));
    chk({tag, ".vec_count"},  vec_count,  64'(m_vec));
    chk({tag, ".err_count"},  err_count,  64'(m_err));
    chk({tag, ".fail_a"},     fail_a,     m_fa);
    chk({tag, ".fail_b"},     fail_b,     m_fb);
    chk({tag, ".fail_cin"},   fail_cin,   64'(m_fci));
    chk({tag, ".fail_sum"},   fail_sum,   m_fs);
    chk({tag, ".fail_cout"},  fail_cout,  64'(m_fco));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [63:0] va, input logic [63:0] vb, input logic vci,
                       input logic [63:0] sum_xor, input logic cout_xor);
    logic [64:0] g;
    g        = 65'(va) + 65'(vb) + 65'(vci);
    a        = va;
    b        = vb;
    c_in     = vci;
    dut_sum  = g[63:0] ^ sum_xor;
    dut_cout = g[64] ^ cout_xor;
    in_valid = 1'b1;
  endtask

  task automatic do_clear_and_run();
    in_valid = 1'b0;
    clear    = 1'b1;
    step("clear");
    clear  = 1'b0;
    enable = 1'b1;
    step("enter_run");
  endtask

  initial begin
    logic [63:0] iv, ra, rb, sx;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; halt_on_err = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; c_in = 1'b0; dut_sum = '0; dut_cout = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // eight correct vectors
    enable = 1'b1;
    step("idle_to_run");
    for (int i = 0; i < 8; i++) begin
      iv = 64'(i);
      drive(iv, iv, iv[0], '0, 1'b0);
      step("good8");
    end
    in_valid = 1'b0;
    step("good8_drain");
    chk("good8.vec_count", vec_count, 64'd8);
    chk("good8.err_count", err_count, 64'd0);
    chk("good8.error_flag", error_flag, 64'd0);
    chk("good8.busy", busy, 64'd1);

    // vector 3 corrupted, no halt
    do_clear_and_run();
    for (int i = 0; i < 8; i++) begin
      iv = 64'(i);
      drive(iv, iv, iv[0], (i == 3) ? 64'd1 : 64'd0, 1'b0);
      step("bad3");
      if (i == 3) chk("bad3.flag_at_sample", error_flag, 64'd0);
      if (i == 4) chk("bad3.flag_next_edge", error_flag, 64'd1);
    end
    in_valid = 1'b0;
    step("bad3_drain");
    chk("bad3.err_count", err_count, 64'd1);
    chk("bad3.vec_count", vec_count, 64'd8);
    chk("bad3.fail_a", fail_a, 64'd3);
    chk("bad3.fail_sum", fail_sum, 64'd6);

    // carry-out boundary
    do_clear_and_run();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, '0, 1'b0);
    step("carry_ok");
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, '0, 1'b1);
    step("carry_bad");
    in_valid = 1'b0;
    step("carry_drain");
    chk("carry.err_count", err_count, 64'd1);
    chk("carry.vec_count", vec_count, 64'd2);
    chk("carry.fail_cout", fail_cout, 64'd0);
    chk("carry.fail_sum", fail_sum, 64'd0);

    // halt on first error
    halt_on_err = 1'b1;
    do_clear_and_run();
    drive(64'd10, 64'd20, 1'b0, 64'h80, 1'b0);
    step("halt_bad");
    for (int i = 0; i < 3; i++) begin
      drive(64'(i), 64'd5, 1'b1, '0, 1'b0);
      step("halt_good");
    end
    chk("halt.halted", halted, 64'd1);
    chk("halt.vec_count", vec_count, 64'd1);
    chk("halt.err_count", err_count, 64'd1);
    drive(64'd1, 64'd1, 1'b0, 64'd1, 1'b0);
    step("halt_ignore");
    step("halt_ignore");
    chk("halt.still_vec", vec_count, 64'd1);
    in_valid = 1'b0;
    clear    = 1'b1;
    step("halt_clear");
    clear = 1'b0;
    chk("halt_clear.halted", halted, 64'd0);
    chk("halt_clear.busy", busy, 64'd0);
    chk("halt_clear.vec_count", vec_count, 64'd0);
    chk("halt_clear.err_count", err_count, 64'd0);
    halt_on_err = 1'b0;

    // counter saturation
    do_clear_and_run();
    for (int i = 0; i < 23; i++) begin
      drive(64'(i * 7), 64'(i * 13), 1'b0, '0, 1'b0);
      step("sat");
      if (i == 21) chk("sat.vec_count", vec_count, 64'd15);
    end
    in_valid = 1'b0;
    step("sat_drain");
    chk("sat.vec_hold", vec_count, 64'd15);

    // randomized traffic with occasional enable drops, clears and halts
    do_clear_and_run();
    for (int i = 0; i < 300; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      clear       = ($urandom_range(0, 49) == 0);
      halt_on_err = (i >= 200) && ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       ra = 64'd0;
        default: ra = {$urandom, $urandom};
      endcase
      rb = {$urandom, $urandom};
      sx = ($urandom_range(0, 4) == 0) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
      drive(ra, rb, 1'($urandom), sx, ($urandom_range(0, 9) == 0));
      in_valid = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    clear = 1'b0;
    halt_on_err = 1'b0;

    // asynchronous reset while running with an error recorded
    do_clear_and_run();
    drive(64'd100, 64'd200, 1'b1, 64'd4, 1'b0);
    step("prerst_bad");
    in_valid = 1'b0;
    step("prerst_cmp");
    chk("prerst.error_flag", error_flag, 64'd1);
    chk("prerst.busy", busy, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n  = 1'b1;
    enable = 1'b0;
    step("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
